// File: rtl/sad_pkg.sv
// Shared definitions for the SAD window-minimum stage.
//   SAD_DIN_W : column SAD width produced by the popcount tree
//   state_e   : controller states
//   sum_width : window-sum width needed to hold NCOL full-scale columns
package sad_pkg;

    localparam int SAD_DIN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int sum_width(input int din_w, input int ncol);
        return din_w + $clog2(ncol);
    endfunction

endpackage

// File: rtl/sad_window_min_if.sv
// Column-beat input stream and result output handshake of sad_window_min.
//   in_valid/in_ready/in_sad          : column SAD beats into the block
//   out_valid/out_ready/out_sad/out_idx : winning candidate out of the block
//   modport slave  : the sad_window_min side
//   modport master : the producer/consumer (testbench) side
interface sad_window_min_if #(
    parameter int DIN_W = 8,
    parameter int SUM_W = 12,
    parameter int IDX_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [DIN_W-1:0] in_sad;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sad;
    logic [IDX_W-1:0] out_idx;

    modport slave (
        input  in_valid, in_sad, out_ready,
        output in_ready, out_valid, out_sad, out_idx
    );

    modport master (
        output in_valid, in_sad, out_ready,
        input  in_ready, out_valid, out_sad, out_idx
    );
endinterface

// File: rtl/sad_min_track.sv
// Running minimum of candidate window sums.
//   upd      : evaluate cand_sum this cycle
//   first    : first candidate of the search, always taken
//   cand_sum : window SAD of the candidate being evaluated
//   cand_idx : its candidate index
//   min_sad/min_idx : current minimum and the index that produced it
module sad_min_track #(
    parameter int SUM_W = 12,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic             first,
    input  logic [SUM_W-1:0] cand_sum,
    input  logic [IDX_W-1:0] cand_idx,
    output logic [SUM_W-1:0] min_sad,
    output logic [IDX_W-1:0] min_idx
);
    logic [SUM_W-1:0] min_sad_q, min_sad_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;

    // Strict less-than: on a tie the earlier candidate stays the winner.
    always_comb begin
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        if (upd && (first || (cand_sum < min_sad_q))) begin
            min_sad_d = cand_sum;
            min_idx_d = cand_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sad_q <= '0;
            min_idx_q <= '0;
        end else begin
            min_sad_q <= min_sad_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign min_sad = min_sad_q;
    assign min_idx = min_idx_q;
endmodule

// File: rtl/sad_window_min.sv
// Sums NCOL column SADs per candidate and reports the minimum window SAD
// and its index over NCAND candidates.
//   clk, rst_n : clock, async active-low reset
//   start      : begins a search (IDLE only)
//   busy       : high in every state but IDLE
//   bus        : column input stream and result output handshake
//
//   state   | meaning
//   IDLE    | waiting for start
//   ACC     | accepting column beats of the current candidate
//   CMP     | comparing the finished candidate sum against the minimum
//   DONE    | loading, then presenting the result until accepted
module sad_window_min
    import sad_pkg::*;
#(
    parameter int NCOL  = 16,
    parameter int NCAND = 32,
    parameter int DIN_W = SAD_DIN_W,
    parameter int SUM_W = sum_width(DIN_W, NCOL),
    parameter int IDX_W = $clog2(NCAND)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    sad_window_min_if.slave      bus
);
    localparam int CNT_W = $clog2(NCOL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] cand_sum_q, cand_sum_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sad_q, out_sad_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             in_ready;
    logic             upd;
    logic [SUM_W-1:0] acc_next;
    logic [SUM_W-1:0] min_sad;
    logic [IDX_W-1:0] min_idx;

    assign acc_next = acc_q + SUM_W'(bus.in_sad);

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        cand_idx_d  = cand_idx_q;
        acc_d       = acc_q;
        cand_sum_d  = cand_sum_q;
        out_valid_d = out_valid_q;
        out_sad_d   = out_sad_q;
        out_idx_d   = out_idx_q;
        in_ready    = 1'b0;
        upd         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    col_cnt_d  = '0;
                    cand_idx_d = '0;
                    acc_d      = '0;
                    state_d    = ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (col_cnt_q == CNT_W'(NCOL - 1)) begin
                        cand_sum_d = acc_next;
                        acc_d      = '0;
                        col_cnt_d  = '0;
                        state_d    = ST_CMP;
                    end else begin
                        acc_d     = acc_next;
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            ST_CMP: begin
                upd = 1'b1;
                if (cand_idx_q == IDX_W'(NCAND - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cand_idx_d = cand_idx_q + 1'b1;
                    state_d    = ST_ACC;
                end
            end
            ST_DONE: begin
                // First DONE cycle registers the winner; the result is then
                // held from flops until the consumer takes it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_sad_d   = min_sad;
                    out_idx_d   = min_idx;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= '0;
            cand_idx_q  <= '0;
            acc_q       <= '0;
            cand_sum_q  <= '0;
            out_valid_q <= 1'b0;
            out_sad_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            cand_idx_q  <= cand_idx_d;
            acc_q       <= acc_d;
            cand_sum_q  <= cand_sum_d;
            out_valid_q <= out_valid_d;
            out_sad_q   <= out_sad_d;
            out_idx_q   <= out_idx_d;
        end
    end

    sad_min_track #(
        .SUM_W (SUM_W),
        .IDX_W (IDX_W)
    ) u_min_track (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd      (upd),
        .first    (cand_idx_q == '0),
        .cand_sum (cand_sum_q),
        .cand_idx (cand_idx_q),
        .min_sad  (min_sad),
        .min_idx  (min_idx)
    );

    assign busy          = (state_q != ST_IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sad   = out_sad_q;
    assign bus.out_idx   = out_idx_q;
endmodule

// File: tb/tb_sad_window_min.sv
module tb_sad_window_min;
    localparam int NCOL  = 16;
    localparam int NCAND = 32;
    localparam int DIN_W = 8;
    localparam int SUM_W = 12;
    localparam int IDX_W = 5;
    localparam int NBEAT = NCOL * NCAND;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    sad_window_min_if #(.DIN_W(DIN_W), .SUM_W(SUM_W), .IDX_W(IDX_W)) bus ();

    sad_window_min #(
        .NCOL(NCOL), .NCAND(NCAND), .DIN_W(DIN_W), .SUM_W(SUM_W), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [SUM_W-1:0] sad;
        logic [IDX_W-1:0] idx;
    } exp_t;
    exp_t sb[$];

    logic [DIN_W-1:0] rnd_tab [NCAND][NCOL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DIN_W-1:0] col_val(input int mode, input int cand, input int col);
        case (mode)
            0: return (cand == 7) ? 8'd3 : 8'd50;
            1: return (cand == 4 || cand == 9) ? 8'd0 : 8'(10 + cand + col);
            2: return 8'd255;
            3: return (cand == 31) ? 8'd1 : 8'd200;
            default: return rnd_tab[cand][col];
        endcase
    endfunction

    // Reference model: strict-less running minimum over window sums.
    task automatic push_expected(input int mode);
        exp_t e;
        int sum;
        int best;
        int best_i;
        best = 0;
        best_i = 0;
        for (int c = 0; c < NCAND; c++) begin
            sum = 0;
            for (int k = 0; k < NCOL; k++) sum += int'(col_val(mode, c, k));
            if (c == 0 || sum < best) begin
                best = sum;
                best_i = c;
            end
        end
        e.sad = SUM_W'(best);
        e.idx = IDX_W'(best_i);
        sb.push_back(e);
    endtask

    // Called at a negedge: raises start for the next edge.
    task automatic start_search();
        start = 1'b1;
        s_cyc = cyc;
    endtask

    task automatic do_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_sad", 32'(bus.out_sad), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        rst_n = 1'b1;
    endtask

    task automatic feed(input int mode, input int stall_pct, input int mid_start,
                        input int abort_beat);
        int beat;
        int budget;
        bit pulsed;
        bit aborted;
        beat = 0;
        budget = 0;
        pulsed = 0;
        aborted = 0;
        while (beat < NBEAT && budget < 5000 && !aborted) begin
            @(negedge clk);
            budget++;
            if (budget == 1) chk("busy_after_start", 32'(busy), 1);
            start = 1'b0;
            if (mid_start >= 0 && beat == mid_start && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (abort_beat >= 0 && beat == abort_beat) begin
                do_reset_mid();
                aborted = 1;
            end else begin
                bus.in_valid = ($urandom_range(0, 99) >= stall_pct);
                bus.in_sad = col_val(mode, beat / NCOL, beat % NCOL);
                if (bus.in_valid && bus.in_ready) beat++;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            start = 1'b0;
            chk("feed_beats", 32'(beat), 32'(NBEAT));
            push_expected(mode);
        end
    endtask

    // Waits for the result, optionally stalls the consumer, then takes it.
    // Returns at the negedge just after the handshake edge.
    task automatic take_result(input string tag, input bit check_lat, input int hold);
        int n;
        exp_t e;
        logic [SUM_W-1:0] s0;
        logic [IDX_W-1:0] i0;
        n = 0;
        while (!bus.out_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
        if (check_lat) chk({tag, "_latency"}, 32'(cyc - s_cyc - 1), 545);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            s0 = bus.out_sad;
            i0 = bus.out_idx;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
                chk({tag, "_hold_sad"}, 32'(bus.out_sad), 32'(s0));
                chk({tag, "_hold_idx"}, 32'(bus.out_idx), 32'(i0));
            end
            chk({tag, "_sad"}, 32'(bus.out_sad), 32'(e.sad));
            chk({tag, "_idx"}, 32'(bus.out_idx), 32'(e.idx));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sad = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < NCAND; c++)
            for (int k = 0; k < NCOL; k++)
                rnd_tab[c][k] = 8'($urandom_range(0, 255));

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 0);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_out_sad", 32'(bus.out_sad), 0);
        chk("reset_out_idx", 32'(bus.out_idx), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Minimum at candidate 7, latency and consumer backpressure.
        start_search();
        feed(0, 0, -1, -1);
        take_result("min7", 1'b1, 10);

        // Back-to-back start; tie at candidates 4 and 9 with a stray start.
        start_search();
        feed(1, 0, 100, -1);
        take_result("tie", 1'b0, 0);

        // Full-scale columns.
        start_search();
        feed(2, 0, -1, -1);
        take_result("full", 1'b0, 0);

        // Same as the first search with 30% input stalls.
        start_search();
        feed(0, 30, -1, -1);
        take_result("stall", 1'b0, 0);

        // Reset during candidate 12, then a fresh search won by candidate 31.
        start_search();
        feed(3, 0, -1, 12 * NCOL + 5);
        @(negedge clk);
        chk("after_abort_busy", 32'(busy), 0);
        start_search();
        feed(3, 0, -1, -1);
        take_result("last", 1'b1, 0);

        // Random columns with stalls.
        start_search();
        feed(4, 30, -1, -1);
        take_result("rand", 1'b0, 2);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
